// File: rtl/lane_rr_scheduler.sv
// Purpose : shares one DATA_W serial lane between four FIFO-buffered requesters, round-robin.
// Latency : word written at edge k is presented (validOut) after edge k+1 if the output register is free and the lane wins.
// Backpr. : readyIn=0 freezes the output register; lanes keep filling until full, further writes are dropped.
//
// Ports: clk/reset (sync, active-high); dataIn0..3/validIn0..3 lane writes;
//        full[3:0] per-lane FIFO full (registered); dataOut/laneOut/validOut/readyIn output handshake;
//        idle = all FIFOs empty and no word held; dropCnt {cnt3..cnt0} only with LANE_RR_SCHEDULER_DROP_CNT_EN.
// Optional feature macro: LANE_RR_SCHEDULER_DROP_CNT_EN (per-lane saturating drop counters).
module lane_rr_scheduler #(
   parameter int DEPTH_LOG2 = 2,
   parameter int DATA_W     = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] dataIn0,
   input  logic [DATA_W-1:0] dataIn1,
   input  logic [DATA_W-1:0] dataIn2,
   input  logic [DATA_W-1:0] dataIn3,
   input  logic              validIn0,
   input  logic              validIn1,
   input  logic              validIn2,
   input  logic              validIn3,
   output logic [3:0]        full,
   output logic [DATA_W-1:0] dataOut,
   output logic              validOut,
   output logic [1:0]        laneOut,
   input  logic              readyIn,
   output logic              idle
`ifdef LANE_RR_SCHEDULER_DROP_CNT_EN
   ,
   output logic [31:0]       dropCnt
`endif
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;
   localparam int PW    = DEPTH_LOG2;

   typedef enum logic {S_EMPTY = 1'b0, S_HOLD = 1'b1} state_t;

   logic [DATA_W-1:0] din [4];
   logic [3:0]        vin;

   assign din[0] = dataIn0;
   assign din[1] = dataIn1;
   assign din[2] = dataIn2;
   assign din[3] = dataIn3;
   assign vin    = {validIn3, validIn2, validIn1, validIn0};

   state_t            state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [1:0]        lane_q, lane_d;
   logic [1:0]        last_q, last_d;
   logic [3:0]        full_q, full_d;
   logic              idle_q, idle_d;
   logic [CW-1:0]     cnt_q [4];
   logic [CW-1:0]     cnt_d [4];
   logic [PW-1:0]     rd_ptr_q [4];
   logic [PW-1:0]     rd_ptr_d [4];
   logic [PW-1:0]     wr_ptr_q [4];
   logic [PW-1:0]     wr_ptr_d [4];
   logic [DATA_W-1:0] mem_q [4][DEPTH];
   logic [DATA_W-1:0] mem_d [4][DEPTH];

   logic [3:0]        nonempty;
   logic [3:0]        wr_en;
   logic [3:0]        pop_lane;
   logic              gnt_vld;
   logic [1:0]        gnt_lane;
   logic              pop;

   // Eligibility uses pre-edge counts, so a word written this cycle waits a cycle.
   always_comb begin
      nonempty = '0;
      for (int n = 0; n < 4; n++) begin
         nonempty[n] = (cnt_q[n] != '0);
      end
   end

   // Search last+1, last+2, ... ; the fourth candidate is last itself.
   always_comb begin : grant
      logic [1:0] cand;
      gnt_vld  = 1'b0;
      gnt_lane = 2'd0;
      cand     = 2'd0;
      for (int i = 1; i <= 4; i++) begin
         cand = last_q + 2'(i);
         if (!gnt_vld && nonempty[cand]) begin
            gnt_vld  = 1'b1;
            gnt_lane = cand;
         end
      end
   end

   assign pop = gnt_vld && ((state_q == S_EMPTY) || readyIn);

   // Per-lane FIFO bookkeeping. full_q is the previous-edge value, so a
   // same-cycle pop never opens room for a write into a full FIFO.
   always_comb begin
      mem_d    = mem_q;
      wr_en    = '0;
      pop_lane = '0;
      full_d   = '0;
      for (int n = 0; n < 4; n++) begin
         wr_en[n]    = vin[n] && !full_q[n];
         pop_lane[n] = pop && (gnt_lane == 2'(n));
         cnt_d[n]    = cnt_q[n] + CW'(wr_en[n]) - CW'(pop_lane[n]);
         wr_ptr_d[n] = wr_en[n]    ? wr_ptr_q[n] + PW'(1) : wr_ptr_q[n];
         rd_ptr_d[n] = pop_lane[n] ? rd_ptr_q[n] + PW'(1) : rd_ptr_q[n];
         full_d[n]   = (cnt_d[n] == CW'(DEPTH));
         if (wr_en[n]) begin
            mem_d[n][wr_ptr_q[n]] = din[n];
         end
      end
   end

   // Output register: a pop always reloads it (back-to-back when readyIn=1);
   // draining with nothing to pop clears valid but keeps the last data/lane.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      lane_d  = lane_q;
      last_d  = last_q;
      if (pop) begin
         data_d  = mem_q[gnt_lane][rd_ptr_q[gnt_lane]];
         lane_d  = gnt_lane;
         last_d  = gnt_lane;
         state_d = S_HOLD;
      end else if ((state_q == S_HOLD) && readyIn) begin
         state_d = S_EMPTY;
      end
      idle_d = (state_d == S_EMPTY);
      for (int n = 0; n < 4; n++) begin
         if (cnt_d[n] != '0) begin
            idle_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_EMPTY;
         data_q  <= '0;
         lane_q  <= 2'd0;
         last_q  <= 2'd3;
         full_q  <= '0;
         idle_q  <= 1'b1;
         for (int n = 0; n < 4; n++) begin
            cnt_q[n]    <= '0;
            rd_ptr_q[n] <= '0;
            wr_ptr_q[n] <= '0;
         end
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         lane_q  <= lane_d;
         last_q  <= last_d;
         full_q  <= full_d;
         idle_q  <= idle_d;
         for (int n = 0; n < 4; n++) begin
            cnt_q[n]    <= cnt_d[n];
            rd_ptr_q[n] <= rd_ptr_d[n];
            wr_ptr_q[n] <= wr_ptr_d[n];
         end
      end
   end

   // Storage is never cleared; reset only rewinds the pointers and counts.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign full     = full_q;
   assign dataOut  = data_q;
   assign laneOut  = lane_q;
   assign validOut = (state_q == S_HOLD);
   assign idle     = idle_q;

`ifdef LANE_RR_SCHEDULER_DROP_CNT_EN
   logic [7:0] drop_q [4];
   logic [7:0] drop_d [4];

   // Saturating count of writes rejected because the lane was full.
   always_comb begin
      for (int n = 0; n < 4; n++) begin
         drop_d[n] = drop_q[n];
         if (vin[n] && full_q[n] && (drop_q[n] != 8'hFF)) begin
            drop_d[n] = drop_q[n] + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int n = 0; n < 4; n++) begin
         if (reset) begin
            drop_q[n] <= '0;
         end else begin
            drop_q[n] <= drop_d[n];
         end
      end
   end

   assign dropCnt = {drop_q[3], drop_q[2], drop_q[1], drop_q[0]};
`endif

endmodule
